// File: rtl/exibe_sequencia.sv
// Memory-game sequence presenter: walks addresses 0..limite, lighting each stored play for T_ACESO cycles then T_APAGADO dark.
// Cost is T_ACESO+T_APAGADO+3 cycles per element; there is no backpressure, and cancelar or reset aborts to INICIAL at any point.
module exibe_sequencia #(
  parameter int T_ACESO   = 500,
  parameter int T_APAGADO = 250,
  parameter int W_TEMPO   = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       cancelar,
  input  logic [3:0] limite,
  input  logic [3:0] mem_dado,
  output logic [3:0] mem_endereco,
  output logic [3:0] leds,
  output logic       ocupado,
  output logic       pronto,
  output logic [3:0] db_estado
);

  localparam logic [2:0] INICIAL = 3'd0;
  localparam logic [2:0] CARREGA = 3'd1;
  localparam logic [2:0] ESPERA  = 3'd2;
  localparam logic [2:0] ACESO   = 3'd3;
  localparam logic [2:0] APAGADO = 3'd4;
  localparam logic [2:0] PROXIMO = 3'd5;
  localparam logic [2:0] FIM     = 3'd6;

  localparam logic [W_TEMPO-1:0] FIM_ACESO   = W_TEMPO'(T_ACESO - 1);
  localparam logic [W_TEMPO-1:0] FIM_APAGADO = W_TEMPO'(T_APAGADO - 1);

  logic [2:0]         estado_q,   estado_d;
  logic [W_TEMPO-1:0] tempo_q,    tempo_d;
  logic [3:0]         limite_q,   limite_d;
  logic [3:0]         endereco_q, endereco_d;
  logic [3:0]         leds_q,     leds_d;

  always_comb begin
    estado_d   = estado_q;
    tempo_d    = tempo_q;
    limite_d   = limite_q;
    endereco_d = endereco_q;
    leds_d     = leds_q;
    if (cancelar) begin
      // Abort keeps the address so a debug view still shows where it stopped.
      estado_d = INICIAL;
      tempo_d  = '0;
      leds_d   = 4'd0;
    end else begin
      case (estado_q)
        INICIAL: begin
          leds_d = 4'd0;
          if (iniciar) begin
            limite_d   = limite;
            endereco_d = 4'd0;
            estado_d   = CARREGA;
          end
        end
        CARREGA: estado_d = ESPERA;
        ESPERA: begin
          leds_d   = mem_dado;
          tempo_d  = '0;
          estado_d = ACESO;
        end
        ACESO: begin
          if (tempo_q == FIM_ACESO) begin
            leds_d   = 4'd0;
            tempo_d  = '0;
            estado_d = APAGADO;
          end else begin
            tempo_d = tempo_q + 1'b1;
          end
        end
        APAGADO: begin
          if (tempo_q == FIM_APAGADO) begin
            tempo_d  = '0;
            estado_d = PROXIMO;
          end else begin
            tempo_d = tempo_q + 1'b1;
          end
        end
        // Compare before increment so address 15 is terminal without wrapping.
        PROXIMO: begin
          if (endereco_q == limite_q) begin
            estado_d = FIM;
          end else begin
            endereco_d = endereco_q + 1'b1;
            estado_d   = CARREGA;
          end
        end
        FIM:     estado_d = INICIAL;
        default: estado_d = INICIAL;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q   <= INICIAL;
      tempo_q    <= '0;
      limite_q   <= 4'd0;
      endereco_q <= 4'd0;
      leds_q     <= 4'd0;
    end else begin
      estado_q   <= estado_d;
      tempo_q    <= tempo_d;
      limite_q   <= limite_d;
      endereco_q <= endereco_d;
      leds_q     <= leds_d;
    end
  end

  assign mem_endereco = endereco_q;
  assign leds         = leds_q;
  assign ocupado      = (estado_q != INICIAL);
  assign pronto       = (estado_q == FIM);
  assign db_estado    = {1'b0, estado_q};

endmodule

// File: tb/tb_exibe_sequencia.sv
// Directed bench for exibe_sequencia with T_ACESO=4, T_APAGADO=2 (9 cycles per element).
module tb_exibe_sequencia;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       iniciar = 1'b0;
  logic       cancelar = 1'b0;
  logic [3:0] limite = 4'd0;
  logic [3:0] mem_dado = 4'd0;
  logic [3:0] mem_endereco;
  logic [3:0] leds;
  logic       ocupado;
  logic       pronto;
  logic [3:0] db_estado;

  logic [3:0] mem [16];
  int errors = 0;
  int checks = 0;

  exibe_sequencia #(.T_ACESO(4), .T_APAGADO(2), .W_TEMPO(16)) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .cancelar(cancelar),
    .limite(limite), .mem_dado(mem_dado), .mem_endereco(mem_endereco),
    .leds(leds), .ocupado(ocupado), .pronto(pronto), .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  always_ff @(posedge clock) mem_dado <= mem[mem_endereco];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] st, input logic [3:0] ld,
                         input logic [3:0] ad, input logic oc, input logic pr);
    chk({tag, ".estado"}, db_estado, st);
    chk({tag, ".leds"}, leds, ld);
    chk({tag, ".endereco"}, mem_endereco, ad);
    chk({tag, ".ocupado"}, ocupado, oc);
    chk({tag, ".pronto"}, pronto, pr);
  endtask

  // Called at a negedge; after edge k the state follows the 9-cycle element pattern.
  task automatic run(input string tag, input logic [3:0] lim, input int stop_at, input bit disturb);
    int total;
    int last;
    int e;
    int p;
    logic [3:0] st;
    logic [3:0] ld;
    total = (int'(lim) + 1) * 9 + 1;
    last  = (stop_at > 0) ? stop_at : total + 1;
    limite  = lim;
    iniciar = 1'b1;
    for (int k = 1; k <= last; k++) begin
      @(posedge clock);
      @(negedge clock);
      if (k < total) begin
        e  = (k - 1) / 9;
        p  = (k - 1) % 9;
        st = (p == 0) ? 4'd1 : (p == 1) ? 4'd2 : (p <= 5) ? 4'd3 : (p <= 7) ? 4'd4 : 4'd5;
        ld = (p >= 2 && p <= 5) ? mem[e] : 4'd0;
        chk_all($sformatf("%s.k%0d", tag, k), st, ld, 4'(e), 1'b1, 1'b0);
      end else if (k == total) begin
        chk_all($sformatf("%s.fim", tag), 4'd6, 4'd0, lim, 1'b1, 1'b1);
      end else begin
        chk_all($sformatf("%s.idle", tag), 4'd0, 4'd0, lim, 1'b0, 1'b0);
      end
      if (k == 1) iniciar = 1'b0;
      if (disturb && k == 4) begin
        iniciar = 1'b1;
        limite  = 4'd0;
      end
      if (disturb && k == 5) iniciar = 1'b0;
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 4'd0;
    #2;
    chk_all("reset", 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk_all("pos_reset", 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);

    // 1: four one-hot plays, pronto at edge 37
    mem[0] = 4'd1; mem[1] = 4'd2; mem[2] = 4'd4; mem[3] = 4'd8;
    run("t1", 4'd3, 0, 1'b0);

    // 2: single element
    mem[0] = 4'b0100;
    run("t2", 4'd0, 0, 1'b0);

    // 3: full 16-element sequence
    for (int i = 0; i < 16; i++) mem[i] = 4'(i);
    run("t3", 4'd15, 0, 1'b0);

    // 4: re-start request and limite change mid-sequence are ignored
    mem[0] = 4'd1; mem[1] = 4'd2; mem[2] = 4'd4; mem[3] = 4'd8;
    run("t4", 4'd3, 0, 1'b1);
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      chk("t4.sem_pronto", pronto, 1'b0);
    end
    chk("t4.inicial", db_estado, 4'd0);

    // iniciar with cancelar in INICIAL stays put
    iniciar = 1'b1; cancelar = 1'b1;
    @(negedge clock);
    chk("ini_canc.estado", db_estado, 4'd0);
    chk("ini_canc.ocupado", ocupado, 1'b0);
    iniciar = 1'b0; cancelar = 1'b0;

    // 5: cancel during ACESO of element 2 (edge 12)
    run("t5", 4'd3, 12, 1'b0);
    cancelar = 1'b1;
    @(negedge clock);
    cancelar = 1'b0;
    chk_all("t5.cancel", 4'd0, 4'd0, 4'd1, 1'b0, 1'b0);
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      chk("t5.sem_pronto", pronto, 1'b0);
    end
    chk("t5.parado", db_estado, 4'd0);

    // 6: async reset mid-APAGADO of element 2 (edge 16), no clock edge involved
    run("t6", 4'd3, 16, 1'b0);
    chk("t6.antes", db_estado, 4'd4);
    #2 reset = 1'b0;
    #1;
    chk_all("t6.reset", 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
    #1 reset = 1'b1;
    @(negedge clock);
    @(negedge clock);
    chk_all("t6.espera", 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
    run("t6r", 4'd1, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
